// File: rtl/tune_decode_if.sv
// Handshake and result bus between a requester and the tuning-word decoder.
interface tune_decode_if #(
  parameter int TW_WIDTH = 28,
  parameter int FS_BITS  = 14
);
  logic                start;
  logic [TW_WIDTH-1:0] tuner;
  logic                busy;
  logic                done;
  logic [FS_BITS-1:0]  freq_bin;
  logic [15:0]         splitDec;

  modport master (
    output start, tuner,
    input  busy, done, freq_bin, splitDec
  );

  modport slave (
    input  start, tuner,
    output busy, done, freq_bin, splitDec
  );
endinterface

// File: rtl/tune_decode.sv
// DDS tuning-word decoder: recovers tuner*FS_HZ/2^TW_WIDTH in Hz (rounded,
// saturated at 9999) as binary and 4-digit BCD.
//
// state | meaning
// IDLE  | waiting for start; results hold their last value
// MUL   | shift-add multiply of captured tuner by FS_HZ, one FS_HZ bit per cycle
// RND   | round half up, saturate, load double-dabble register
// BCD   | double-dabble conversion, one bit per cycle; results publish on the last
module tune_decode #(
  parameter int TW_WIDTH = 28,
  parameter int FS_HZ    = 10000,
  parameter int FS_BITS  = 14
) (
  input logic         clk,
  input logic         clr,
  tune_decode_if.slave bus
);

  localparam int ACC_W = TW_WIDTH + FS_BITS;
  localparam int DD_W  = 16 + FS_BITS;
  localparam int CNT_W = $clog2(FS_BITS);
  localparam int MAX_Q = 9999;
  localparam logic [FS_BITS-1:0] FS_VEC = FS_BITS'(FS_HZ);

  typedef enum logic [1:0] {IDLE, MUL, RND, BCD} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [TW_WIDTH-1:0] tuner_q;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic [FS_BITS-1:0]  q_reg;
  logic [DD_W-1:0]     dd;

  logic                cnt_last;
  logic [ACC_W-1:0]    addend;
  logic [ACC_W-1:0]    rnd_sum;
  logic [ACC_W-1:0]    rnd_q;
  logic [FS_BITS-1:0]  q_sat;
  logic [DD_W-1:0]     dd_adj;
  logic [DD_W-1:0]     dd_shift;

  // Datapath helpers: multiply addend, rounding/saturation, double-dabble step.
  always_comb begin
    cnt_last = (cnt == CNT_W'(FS_BITS - 1));
    addend   = ACC_W'(tuner_q) << cnt;
    rnd_sum  = acc + (ACC_W'(1) << (TW_WIDTH - 1));
    rnd_q    = rnd_sum >> TW_WIDTH;
    q_sat    = (rnd_q > ACC_W'(MAX_Q)) ? FS_BITS'(MAX_Q) : rnd_q[FS_BITS-1:0];
    dd_adj   = dd;
    for (int i = 0; i < 4; i++) begin
      if (dd_adj[FS_BITS+4*i +: 4] >= 4'd5) begin
        dd_adj[FS_BITS+4*i +: 4] = dd_adj[FS_BITS+4*i +: 4] + 4'd3;
      end
    end
    dd_shift = dd_adj << 1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so it never queues.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = MUL;
      MUL:     if (cnt_last) state_nxt = RND;
      RND:     state_nxt = BCD;
      BCD:     if (cnt_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Busy covers every non-idle state, so it drops in the cycle done is high.
  always_comb begin
    bus.busy = (state != IDLE);
  end

  // Datapath registers and published results.
  always_ff @(posedge clk) begin
    if (clr) begin
      tuner_q      <= '0;
      acc          <= '0;
      cnt          <= '0;
      q_reg        <= '0;
      dd           <= '0;
      bus.done     <= 1'b0;
      bus.freq_bin <= '0;
      bus.splitDec <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            tuner_q <= bus.tuner;
            acc     <= '0;
            cnt     <= '0;
          end
        end
        MUL: begin
          if (FS_VEC[cnt]) acc <= acc + addend;
          cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
        end
        RND: begin
          q_reg <= q_sat;
          dd    <= {16'b0, q_sat};
          cnt   <= '0;
        end
        BCD: begin
          dd  <= dd_shift;
          cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
          if (cnt_last) begin
            bus.freq_bin <= q_reg;
            bus.splitDec <= dd_shift[DD_W-1 -: 16];
            bus.done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
